// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
// Holds the FSM state encoding, the port ids and the latency counter sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W       = 4;

    // The counter holds the number of ACCESS cycles still to run after the current one.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        if (lat < MEM_LAT_MIN)
            return '0;
        else if (lat > MEM_LAT_MAX)
            return CNT_W'(MEM_LAT_MAX - 1);
        else
            return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter that times the RAM access window.
// zero flags the last ACCESS cycle; the count stops at zero.
module mem_latency_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/memory_access_arbiter.sv
// Arbitrates the single-port system RAM between instruction fetch and load/store.
// Round-robin on ties, fixed MEM_LAT access window, MOV/MOC four-phase completion.
module memory_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_mov,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_moc,
    input  logic          d_mov,
    input  logic          d_rw,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_moc,
    output logic          mem_en,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          grant_d
);

    state_t state;
    port_t  port_sel;
    port_t  last_grant;
    port_t  pick;
    logic   gnt_mov;
    logic   cnt_load;
    logic   cnt_zero;

    always_comb begin
        pick = PORT_INSTR;
        if (i_mov && d_mov)
            pick = (last_grant == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
        else if (d_mov)
            pick = PORT_DATA;
    end

    assign gnt_mov  = (port_sel == PORT_DATA) ? d_mov : i_mov;
    assign cnt_load = (state == ST_IDLE) && (i_mov || d_mov);

    mem_latency_counter u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .en       (state == ST_ACCESS),
        .load_val (lat_load(MEM_LAT)),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            port_sel   <= PORT_INSTR;
            last_grant <= PORT_DATA;
            grant_d    <= 1'b0;
            mem_en     <= 1'b0;
            mem_rw     <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_mov || d_mov) begin
                        port_sel   <= pick;
                        last_grant <= pick;
                        grant_d    <= (pick == PORT_DATA);
                        mem_en     <= 1'b1;
                        mem_addr   <= (pick == PORT_DATA) ? d_addr : i_addr;
                        mem_rw     <= (pick == PORT_DATA) ? d_rw : 1'b1;
                        mem_wdata  <= d_wdata;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // A dropped request aborts: no capture, no MOC; a write may already have landed.
                    if (!gnt_mov) begin
                        mem_en  <= 1'b0;
                        grant_d <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (cnt_zero) begin
                        if (mem_rw) begin
                            if (port_sel == PORT_DATA)
                                d_rdata <= mem_rdata;
                            else
                                i_rdata <= mem_rdata;
                        end
                        mem_en <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!gnt_mov) begin
                        grant_d <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    mem_en  <= 1'b0;
                    grant_d <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // MOC is gated by the requester's MOV so it falls in the same cycle MOV is released.
    assign i_moc = (state == ST_DONE) && (port_sel == PORT_INSTR) && i_mov;
    assign d_moc = (state == ST_DONE) && (port_sel == PORT_DATA) && d_mov;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Scoreboard bench for memory_access_arbiter: requester tasks push expectations,
// monitors compare grants and completions; extra instances probe MEM_LAT=1 and 15.
module tb_memory_access_arbiter;

    localparam int LAT = 2;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_mov = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_moc;
    logic        d_mov = 1'b0;
    logic        d_rw = 1'b1;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_moc;
    logic        mem_en;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        grant_d;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 0;

    exp_t i_q[$];
    exp_t d_q[$];
    bit   grant_log[$];
    logic [31:0] ram[logic [31:0]];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] i_last = '0;
    logic [31:0] d_last = '0;

    always #5 clk = ~clk;

    memory_access_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(rst),
        .i_mov(i_mov), .i_addr(i_addr), .i_rdata(i_rdata), .i_moc(i_moc),
        .d_mov(d_mov), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_moc(d_moc),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant_d(grant_d)
    );

    // Latency-only instances: index 0 has MEM_LAT=1, index 1 has MEM_LAT=15.
    logic        x_i_mov [2] = '{1'b0, 1'b0};
    logic [31:0] x_i_rdata [2];
    logic        x_i_moc [2];
    logic [31:0] x_d_rdata [2];
    logic        x_d_moc [2];
    logic        x_mem_en [2];
    logic        x_mem_rw [2];
    logic [31:0] x_mem_addr [2];
    logic [31:0] x_mem_wdata [2];
    logic        x_grant_d [2];

    for (genvar g = 0; g < 2; g++) begin : g_lat
        memory_access_arbiter #(.MEM_LAT(g == 0 ? 1 : 15), .AW(32), .DW(32)) u_x (
            .clk(clk), .reset(rst),
            .i_mov(x_i_mov[g]), .i_addr(32'h40), .i_rdata(x_i_rdata[g]), .i_moc(x_i_moc[g]),
            .d_mov(1'b0), .d_rw(1'b1), .d_addr(32'h0), .d_wdata(32'h0),
            .d_rdata(x_d_rdata[g]), .d_moc(x_d_moc[g]),
            .mem_en(x_mem_en[g]), .mem_rw(x_mem_rw[g]), .mem_addr(x_mem_addr[g]),
            .mem_wdata(x_mem_wdata[g]), .mem_rdata(32'hCAFE_0000 + 32'(g)),
            .grant_d(x_grant_d[g])
        );
    end

    function automatic logic [31:0] def_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : def_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RAM device: read data is valid only in the final access cycle, garbage otherwise.
    initial begin
        int acc = 0;
        forever begin
            @(posedge clk);
            #1;
            acc = mem_en ? acc + 1 : 0;
            if (mem_en && mem_rw && acc == LAT)
                mem_rdata = ram.exists(mem_addr) ? ram[mem_addr] : def_word(mem_addr);
            else
                mem_rdata = $urandom;
            if (mem_en && !mem_rw && acc == LAT)
                ram[mem_addr] = mem_wdata;
        end
    end

    // Monitor: grant contents at the start of each RAM window, results at each MOC rise.
    initial begin
        bit pe = 0, pi = 0, pd = 0, chk = 0;
        int run = 0;
        logic [31:0] a0 = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_en && !pe) begin
                grant_log.push_back(grant_d);
                run = 0;
                chk = mon_en;
                a0 = mem_addr;
                if (chk) begin
                    if (grant_d ? (d_q.size() == 0) : (i_q.size() == 0)) begin
                        n_cmp++; n_bad++;
                        $display("FAIL grant_unexpected: grant_d=%0b with no pending request", grant_d);
                    end else if (grant_d) begin
                        e = d_q[0];
                        check("d_mem_addr", mem_addr, e.addr);
                        check("d_mem_rw", {31'b0, mem_rw}, {31'b0, e.rw});
                        if (!e.rw) check("d_mem_wdata", mem_wdata, e.wdata);
                    end else begin
                        e = i_q[0];
                        check("i_mem_addr", mem_addr, e.addr);
                        check("i_mem_rw", {31'b0, mem_rw}, 32'd1);
                    end
                end
            end
            if (mem_en) begin
                run++;
                if (chk && run > 1) check("mem_addr_stable", mem_addr, a0);
            end
            if (!mem_en && pe && chk) check("mem_en_len", 32'(run), 32'(LAT));
            check("moc_exclusive", {31'b0, i_moc & d_moc}, 32'd0);
            if (i_moc && !pi) begin
                if (i_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL i_moc_unexpected: i_moc rose with nothing pending");
                end else begin
                    e = i_q.pop_front();
                    check("i_rdata", i_rdata, e.rdata);
                end
            end
            if (d_moc && !pd) begin
                if (d_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL d_moc_unexpected: d_moc rose with nothing pending");
                end else begin
                    e = d_q.pop_front();
                    check("d_rdata", d_rdata, e.rdata);
                end
            end
            pe = mem_en;
            pi = i_moc;
            pd = d_moc;
        end
    end

    // Called at drive time; returns at drive time in the IDLE cycle after MOV is released.
    task automatic do_i(input logic [31:0] a, input logic [31:0] exp, input int exp_lat, input int hold);
        exp_t e;
        int lat = 0;
        bit seen = 0;
        e.addr = a; e.rw = 1'b1; e.wdata = '0; e.rdata = exp;
        i_q.push_back(e);
        i_last = exp;
        i_addr = a;
        i_mov = 1'b1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (i_moc) seen = 1; else lat++;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL i_timeout: no i_moc within 200 cycles, addr %h", a);
        end else if (exp_lat > 0) begin
            check("i_latency", 32'(lat), 32'(exp_lat));
        end else begin
            check("i_latency_bound", {31'b0, (lat >= LAT + 1) && (lat <= 2 * LAT + 8)}, 32'd1);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("i_moc_hold", {31'b0, i_moc}, 32'd1);
        end
        step();
        i_mov = 1'b0;
        i_addr = $urandom;
        @(negedge clk);
        check("i_moc_drop", {31'b0, i_moc}, 32'd0);
        step();
    endtask

    task automatic do_d(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, input int hold);
        exp_t e;
        int lat = 0;
        bit seen = 0;
        e.addr = a; e.rw = rw; e.wdata = wd;
        if (rw) begin
            e.rdata = model_read(a);
            d_last = e.rdata;
        end else begin
            model_mem[a] = wd;
            e.rdata = d_last;
        end
        d_q.push_back(e);
        d_rw = rw; d_addr = a; d_wdata = wd;
        d_mov = 1'b1;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (d_moc) seen = 1; else lat++;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL d_timeout: no d_moc within 200 cycles, addr %h", a);
        end else if (exp_lat > 0) begin
            check("d_latency", 32'(lat), 32'(exp_lat));
        end else begin
            check("d_latency_bound", {31'b0, (lat >= LAT + 1) && (lat <= 2 * LAT + 8)}, 32'd1);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("d_moc_hold", {31'b0, d_moc}, 32'd1);
        end
        step();
        d_mov = 1'b0;
        d_rw = $urandom; d_addr = $urandom; d_wdata = $urandom;
        @(negedge clk);
        check("d_moc_drop", {31'b0, d_moc}, 32'd0);
        step();
    endtask

    task automatic lat_probe(input int g, input int lat);
        int en_cnt = 0;
        int moc_at = -1;
        x_i_mov[g] = 1'b1;
        for (int c = 0; c < lat + 6; c++) begin
            @(negedge clk);
            if (x_mem_en[g]) en_cnt++;
            if (x_i_moc[g] && moc_at < 0) moc_at = c;
        end
        check($sformatf("lat%0d_mem_en_cycles", lat), 32'(en_cnt), 32'(lat));
        check($sformatf("lat%0d_moc_cycle", lat), 32'(moc_at), 32'(lat + 1));
        check($sformatf("lat%0d_rdata", lat), x_i_rdata[g], 32'hCAFE_0000 + 32'(g));
        step();
        x_i_mov[g] = 1'b0;
        @(negedge clk);
        check($sformatf("lat%0d_moc_drop", lat), {31'b0, x_i_moc[g]}, 32'd0);
        step();
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_i_moc", {31'b0, i_moc}, 32'd0);
        check("rst_d_moc", {31'b0, d_moc}, 32'd0);
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check("rst_mem_rw", {31'b0, mem_rw}, 32'd1);
        check("rst_grant_d", {31'b0, grant_d}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Reset pulsed during the second ACCESS cycle of a data read
        d_rw = 1'b1; d_addr = 32'h300; d_mov = 1'b1;
        step();
        @(negedge clk);
        check("rstmid_access1_en", {31'b0, mem_en}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        d_mov = 1'b0;
        @(negedge clk);
        check("rstmid_mem_en", {31'b0, mem_en}, 32'd0);
        check("rstmid_d_moc", {31'b0, d_moc}, 32'd0);
        check("rstmid_grant_d", {31'b0, grant_d}, 32'd0);
        check("rstmid_d_rdata", d_rdata, 32'd0);
        step();
        @(negedge clk);
        check("rstmid_idle_en", {31'b0, mem_en}, 32'd0);
        step();
        mon_en = 1;

        // Instruction fetch, then a data write and read-back
        ram[32'h100] = 32'hDEAD_BEEF;
        do_i(32'h100, 32'hDEAD_BEEF, LAT + 1, 2);
        check("fetch_i_rdata_hold", i_rdata, 32'hDEAD_BEEF);
        do_d(1'b0, 32'h200, 32'h1234_5678, LAT + 1, 1);
        check("write_d_rdata_hold", d_rdata, 32'd0);
        do_d(1'b1, 32'h200, 32'h0, LAT + 1, 0);

        // Ties: last grant was data, so instruction first; then data first after a lone fetch
        grant_log.delete();
        fork
            do_i(32'h4000, model_read(32'h4000), -1, 0);
            do_d(1'b1, 32'h8000, 32'h0, -1, 0);
        join
        do_i(32'h4004, model_read(32'h4004), LAT + 1, 0);
        fork
            do_i(32'h4008, model_read(32'h4008), -1, 1);
            do_d(1'b0, 32'h8004, $urandom, -1, 1);
        join
        check("tie_log_len", 32'(grant_log.size()), 32'd5);
        if (grant_log.size() == 5) begin
            check("tie1_first", {31'b0, grant_log[0]}, 32'd0);
            check("tie1_second", {31'b0, grant_log[1]}, 32'd1);
            check("lone_fetch", {31'b0, grant_log[2]}, 32'd0);
            check("tie2_first", {31'b0, grant_log[3]}, 32'd1);
            check("tie2_second", {31'b0, grant_log[4]}, 32'd0);
        end

        // Abort: fetch released in its first ACCESS cycle, pending data read served next
        mon_en = 0;
        i_addr = 32'h180;
        i_mov = 1'b1;
        step();
        i_mov = 1'b0;
        fork
            do_d(1'b1, 32'h8008, 32'h0, LAT + 2, 0);
            begin
                @(negedge clk);
                check("abort_access_en", {31'b0, mem_en}, 32'd1);
                check("abort_access_port", {31'b0, grant_d}, 32'd0);
                @(negedge clk);
                check("abort_idle_en", {31'b0, mem_en}, 32'd0);
                @(negedge clk);
                check("abort_d_grant", {31'b0, mem_en & grant_d}, 32'd1);
                check("abort_d_addr", mem_addr, 32'h8008);
            end
        join
        check("abort_i_rdata", i_rdata, i_last);
        mon_en = 1;

        // Randomized concurrent traffic
        fork
            for (int n = 0; n < 40; n++) begin
                logic [31:0] a;
                repeat ($urandom_range(0, 4)) step();
                a = 32'h4000 + {24'b0, 6'($urandom_range(0, 63)), 2'b00};
                do_i(a, model_read(a), -1, $urandom_range(0, 2));
            end
            for (int n = 0; n < 40; n++) begin
                logic [31:0] a;
                repeat ($urandom_range(0, 4)) step();
                a = 32'h8000 + {26'b0, 4'($urandom_range(0, 15)), 2'b00};
                do_d(1'($urandom_range(0, 1)), a, $urandom, -1, $urandom_range(0, 2));
            end
        join

        // Latency extremes
        lat_probe(0, 1);
        lat_probe(1, 15);

        repeat (3) step();
        check("i_queue_empty", 32'(i_q.size()), 32'd0);
        check("d_queue_empty", 32'(d_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
